// File: rtl/ccsds_demod_pkg.sv
// ---------------------------------------------------------------------------
// ccsds_demod_pkg
// Shared types and constants for the QPSK hard-decision demodulator.
//   demod_state_e : FSM states (IDLE, INTEGRATE, DUMP)
//   qpsk_sym_t    : decided 2-bit symbol {bI, bQ}
//   QPSK_AMPL     : nominal TX constellation amplitude
//   sat_soft()    : saturate a sign-extended, pre-shifted sum to SOFT_W bits
// ---------------------------------------------------------------------------
package ccsds_demod_pkg;

  localparam int DEF_MAX_SPS  = 16;
  localparam int DEF_SAMPLE_W = 13;
  localparam int SOFT_W       = 8;
  localparam int QPSK_AMPL    = 2**12 - 1;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    INTEGRATE = 2'd1,
    DUMP      = 2'd2
  } demod_state_e;

  typedef logic [1:0] qpsk_sym_t;

  function automatic logic signed [SOFT_W-1:0] sat_soft(input logic signed [31:0] v);
    logic signed [31:0] hi;
    logic signed [31:0] lo;
    hi = (2**(SOFT_W-1)) - 1;
    lo = ~hi;
    if (v > hi)
      sat_soft = hi[SOFT_W-1:0];
    else if (v < lo)
      sat_soft = lo[SOFT_W-1:0];
    else
      sat_soft = v[SOFT_W-1:0];
  endfunction

endpackage

// File: rtl/ccsds_demodulator_if.sv
// ---------------------------------------------------------------------------
// ccsds_demodulator_if
// Sample stream in, decided symbol out.
//   sample_valid, i_data, q_data : baseband sample stream (source -> demod)
//   bits, bits_valid, bits_ready : decided symbol valid/ready handshake
//   overflow                     : sticky dropped-symbol flag
// master = sample source / symbol sink, slave = demodulator.
// ---------------------------------------------------------------------------
interface ccsds_demodulator_if #(
  parameter int SAMPLE_W = 13
);
  import ccsds_demod_pkg::*;

  logic                       sample_valid;
  logic signed [SAMPLE_W-1:0] i_data;
  logic signed [SAMPLE_W-1:0] q_data;
  qpsk_sym_t                  bits;
  logic                       bits_valid;
  logic                       bits_ready;
  logic                       overflow;

  modport master (
    output sample_valid, i_data, q_data, bits_ready,
    input  bits, bits_valid, overflow
  );

  modport slave (
    input  sample_valid, i_data, q_data, bits_ready,
    output bits, bits_valid, overflow
  );

endinterface

// File: rtl/ccsds_iq_integrator.sv
// ---------------------------------------------------------------------------
// ccsds_iq_integrator
// One signed integrate-and-dump channel.
//   clk_i, rst_i : clock, async active-high reset
//   clear_i      : discard running sum this cycle
//   add_i        : add sample_i (after any clear, so clear+add loads sample_i)
//   sample_i     : signed sample, SAMPLE_W bits
//   acc_o        : running sum, ACC_W bits
// ---------------------------------------------------------------------------
module ccsds_iq_integrator
  import ccsds_demod_pkg::*;
#(
  parameter int SAMPLE_W = DEF_SAMPLE_W,
  parameter int ACC_W    = DEF_SAMPLE_W + 4
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       clear_i,
  input  logic                       add_i,
  input  logic signed [SAMPLE_W-1:0] sample_i,
  output logic signed [ACC_W-1:0]    acc_o
);

  logic signed [ACC_W-1:0] acc_q;
  logic signed [ACC_W-1:0] acc_d;
  logic signed [ACC_W-1:0] sample_ext;
  logic signed [ACC_W-1:0] base;

  assign sample_ext = {{(ACC_W-SAMPLE_W){sample_i[SAMPLE_W-1]}}, sample_i};

  always_comb begin
    base  = clear_i ? '0 : acc_q;
    acc_d = add_i ? (base + sample_ext) : base;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) acc_q <= '0;
    else       acc_q <= acc_d;
  end

  assign acc_o = acc_q;

endmodule

// File: rtl/ccsds_demodulator.sv
// ---------------------------------------------------------------------------
// ccsds_demodulator
// QPSK hard-decision demodulator: integrate-and-dump over samples_per_symbol_i
// samples, decide {sum_I<0, sum_Q<0}, present on a single-entry valid/ready
// output register.
//   clk_i                : system clock
//   rst_i                : async active-high reset
//   enable_i             : 0 flushes to IDLE (output register kept)
//   sync_i               : restart symbol integration
//   samples_per_symbol_i : samples per symbol, latched at symbol start
//   bus (slave)          : sample stream in, symbol handshake out, overflow
//   soft_i_o, soft_q_o   : saturated soft sums (CCSDS_DEMOD_SOFT_EN only)
// Optional feature macro: CCSDS_DEMOD_SOFT_EN
//
// state     | meaning
// IDLE      | disabled, accumulators held at zero, samples ignored
// INTEGRATE | accumulating samples of the current symbol
// DUMP      | accumulators hold a full symbol; decide this cycle, and a
//           | sample arriving now starts the next symbol
// ---------------------------------------------------------------------------
module ccsds_demodulator
  import ccsds_demod_pkg::*;
#(
  parameter int MAX_SPS  = DEF_MAX_SPS,
  parameter int SAMPLE_W = DEF_SAMPLE_W
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     enable_i,
  input  logic                     sync_i,
  input  logic [31:0]              samples_per_symbol_i,
  ccsds_demodulator_if.slave       bus
`ifdef CCSDS_DEMOD_SOFT_EN
  ,
  output logic signed [SOFT_W-1:0] soft_i_o,
  output logic signed [SOFT_W-1:0] soft_q_o
`endif
);

  localparam int ACC_W = SAMPLE_W + $clog2(MAX_SPS);
  localparam int CNT_W = $clog2(MAX_SPS + 1);

  demod_state_e     state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] sps_q, sps_d;
  logic [CNT_W-1:0] sps_new;
  logic [CNT_W-1:0] base_cnt;
  logic [CNT_W-1:0] base_sps;
  logic             acc_clear;
  logic             acc_add;
  logic             decide;

  logic signed [ACC_W-1:0] i_sum;
  logic signed [ACC_W-1:0] q_sum;

  qpsk_sym_t bits_q, bits_d;
  logic      bits_valid_q, bits_valid_d;
  logic      overflow_q, overflow_d;

  // Effective samples per symbol: 0 is treated as 1, large values clamp.
  always_comb begin
    if (samples_per_symbol_i == 32'd0)
      sps_new = CNT_W'(1);
    else if (samples_per_symbol_i > 32'(MAX_SPS))
      sps_new = CNT_W'(MAX_SPS);
    else
      sps_new = samples_per_symbol_i[CNT_W-1:0];
  end

  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    sps_d     = sps_q;
    base_cnt  = count_q;
    base_sps  = sps_q;
    acc_clear = 1'b0;
    acc_add   = 1'b0;
    decide    = 1'b0;
    case (state_q)
      IDLE: begin
        acc_clear = 1'b1;
        count_d   = '0;
        if (enable_i) begin
          state_d = INTEGRATE;
          sps_d   = sps_new;
        end
      end
      INTEGRATE, DUMP: begin
        // A completed symbol in DUMP is always decided, even if disabled now.
        decide = (state_q == DUMP);
        if (!enable_i) begin
          state_d   = IDLE;
          acc_clear = 1'b1;
          count_d   = '0;
        end else begin
          // DUMP and sync both start a fresh symbol this cycle; DUMP also
          // picks up any new samples-per-symbol value.
          if (state_q == DUMP) begin
            base_sps = sps_new;
            sps_d    = sps_new;
          end
          if ((state_q == DUMP) || sync_i)
            base_cnt = '0;
          acc_clear = (state_q == DUMP) || sync_i;
          state_d   = INTEGRATE;
          count_d   = base_cnt;
          if (bus.sample_valid) begin
            acc_add = 1'b1;
            if (base_cnt == (base_sps - CNT_W'(1))) begin
              state_d = DUMP;
              count_d = '0;
            end else begin
              count_d = base_cnt + CNT_W'(1);
            end
          end
        end
      end
      default: begin
        state_d   = IDLE;
        acc_clear = 1'b1;
        count_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q <= IDLE;
      count_q <= '0;
      sps_q   <= CNT_W'(1);
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      sps_q   <= sps_d;
    end
  end

  ccsds_iq_integrator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_int_i (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (acc_clear),
    .add_i    (acc_add),
    .sample_i (bus.i_data),
    .acc_o    (i_sum)
  );

  ccsds_iq_integrator #(.SAMPLE_W(SAMPLE_W), .ACC_W(ACC_W)) u_int_q (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .clear_i  (acc_clear),
    .add_i    (acc_add),
    .sample_i (bus.q_data),
    .acc_o    (q_sum)
  );

`ifdef CCSDS_DEMOD_SOFT_EN
  localparam int SOFT_SHIFT = ACC_W - SOFT_W - 2;
  logic signed [SOFT_W-1:0] soft_i_q, soft_i_d;
  logic signed [SOFT_W-1:0] soft_q_q, soft_q_d;
  logic signed [31:0]       i_ext;
  logic signed [31:0]       q_ext;
`endif

  always_comb begin
    bits_d       = bits_q;
    bits_valid_d = bits_valid_q;
    overflow_d   = overflow_q;
`ifdef CCSDS_DEMOD_SOFT_EN
    soft_i_d = soft_i_q;
    soft_q_d = soft_q_q;
    i_ext    = 32'(i_sum);
    q_ext    = 32'(q_sum);
    i_ext    = i_ext >>> SOFT_SHIFT;
    q_ext    = q_ext >>> SOFT_SHIFT;
`endif
    if (decide) begin
      // Register free or being drained this cycle: reload; otherwise the
      // new symbol is lost and the old one stays put.
      if (!bits_valid_q || bus.bits_ready) begin
        bits_d       = {i_sum[ACC_W-1], q_sum[ACC_W-1]};
        bits_valid_d = 1'b1;
`ifdef CCSDS_DEMOD_SOFT_EN
        soft_i_d = sat_soft(i_ext);
        soft_q_d = sat_soft(q_ext);
`endif
      end else begin
        overflow_d = 1'b1;
      end
    end else if (bits_valid_q && bus.bits_ready) begin
      bits_valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      bits_q       <= '0;
      bits_valid_q <= 1'b0;
      overflow_q   <= 1'b0;
`ifdef CCSDS_DEMOD_SOFT_EN
      soft_i_q     <= '0;
      soft_q_q     <= '0;
`endif
    end else begin
      bits_q       <= bits_d;
      bits_valid_q <= bits_valid_d;
      overflow_q   <= overflow_d;
`ifdef CCSDS_DEMOD_SOFT_EN
      soft_i_q     <= soft_i_d;
      soft_q_q     <= soft_q_d;
`endif
    end
  end

  assign bus.bits       = bits_q;
  assign bus.bits_valid = bits_valid_q;
  assign bus.overflow   = overflow_q;

`ifdef CCSDS_DEMOD_SOFT_EN
  assign soft_i_o = soft_i_q;
  assign soft_q_o = soft_q_q;
`endif

endmodule

// File: tb/tb_ccsds_demodulator.sv
// ---------------------------------------------------------------------------
// tb_ccsds_demodulator
// Directed stimulus with a symbol scoreboard: each stimulus block pushes the
// symbols it expects; an independent monitor pops and compares on every
// accepted handshake. Timing, overflow and reset behaviour are checked
// directly. Soft-output checks run when CCSDS_DEMOD_SOFT_EN is defined.
// ---------------------------------------------------------------------------
module tb_ccsds_demodulator;
  import ccsds_demod_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic        enable;
  logic        sync;
  logic [31:0] sps;

  ccsds_demodulator_if #(.SAMPLE_W(13)) bus_if ();

`ifdef CCSDS_DEMOD_SOFT_EN
  logic signed [SOFT_W-1:0] soft_i;
  logic signed [SOFT_W-1:0] soft_q;
`endif

  ccsds_demodulator #(.MAX_SPS(16), .SAMPLE_W(13)) dut (
    .clk_i                (clk),
    .rst_i                (rst),
    .enable_i             (enable),
    .sync_i               (sync),
    .samples_per_symbol_i (sps),
    .bus                  (bus_if)
`ifdef CCSDS_DEMOD_SOFT_EN
    ,
    .soft_i_o             (soft_i),
    .soft_q_o             (soft_q)
`endif
  );

  always #5 clk = ~clk;

  qpsk_sym_t exp_q[$];
  int vectors     = 0;
  int miscompares = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    vectors++;
    if (act !== req) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, req);
    end
  endtask

  // Scoreboard monitor: every accepted symbol must match the queue head.
  always @(negedge clk) begin : monitor
    qpsk_sym_t e;
    if (rst === 1'b0 && bus_if.bits_valid === 1'b1 && bus_if.bits_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        vectors++;
        miscompares++;
        $display("FAIL unexpected_symbol: got %0d, expected none", bus_if.bits);
      end else begin
        e = exp_q.pop_front();
        check("symbol", 32'(bus_if.bits), 32'(e));
      end
    end
  end

  initial begin : watchdog
    #200us;
    $display("FAIL timeout: simulation did not complete, expected finish");
    $fatal(1, "timeout");
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input int i, input int q);
    bus_if.sample_valid = 1'b1;
    bus_if.i_data       = 13'(i);
    bus_if.q_data       = 13'(q);
    tick();
  endtask

  task automatic drain(input string name);
    bus_if.sample_valid = 1'b0;
    repeat (8) tick();
    check({name, "_drain"}, 32'(exp_q.size()), 0);
  endtask

  task automatic restart(input int s);
    enable = 1'b0;
    tick();
    sps    = 32'(s);
    enable = 1'b1;
    tick();
  endtask

  initial begin
    rst                 = 1'b1;
    enable              = 1'b0;
    sync                = 1'b0;
    sps                 = 32'd4;
    bus_if.sample_valid = 1'b0;
    bus_if.i_data       = '0;
    bus_if.q_data       = '0;
    bus_if.bits_ready   = 1'b1;
    repeat (3) tick();
    check("rst_bits", 32'(bus_if.bits), 0);
    check("rst_valid", 32'(bus_if.bits_valid), 0);
    check("rst_overflow", 32'(bus_if.overflow), 0);
    rst = 1'b0;
    tick();

    // Single symbol, latency and one-cycle valid pulse.
    enable = 1'b1;
    tick();
    exp_q.push_back(2'b01);
    repeat (4) send(100, -50);
    bus_if.sample_valid = 1'b0;
    check("lat_cycle1_valid", 32'(bus_if.bits_valid), 0);
    tick();
    check("lat_cycle2_valid", 32'(bus_if.bits_valid), 1);
    tick();
    check("lat_pulse_end", 32'(bus_if.bits_valid), 0);
    drain("lat");

    // Back-to-back TX-amplitude symbols 00,01,10,11.
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back(2'(s));
    end
    for (int s = 0; s < 4; s++) begin
      repeat (4) send((s >= 2) ? -QPSK_AMPL : QPSK_AMPL,
                      (s % 2 == 1) ? -QPSK_AMPL : QPSK_AMPL);
    end
    drain("b2b");
    check("b2b_overflow", 32'(bus_if.overflow), 0);

    // sps=0 -> one symbol per sample, including a zero-sum tie.
    restart(0);
    exp_q.push_back(2'b01);
    exp_q.push_back(2'b10);
    exp_q.push_back(2'b00);
    send(5, -5);
    send(-7, 3);
    send(0, 0);
    drain("sps0");

    // sps=100 clamps to 16; only the 16th sample flips the I sign.
    restart(100);
    exp_q.push_back(2'b10);
    repeat (15) send(10, 3);
    send(-200, 3);
    drain("sps100");

    // sync after 2 samples: the sync-cycle sample is sample 0.
    restart(4);
    exp_q.push_back(2'b00);
    repeat (2) send(-1000, -1000);
    sync = 1'b1;
    send(10, 10);
    sync = 1'b0;
    repeat (3) send(10, 10);
    drain("sync");

    // Output stalled across two symbols: first held, second dropped.
    bus_if.bits_ready = 1'b0;
    exp_q.push_back(2'b10);
    repeat (4) send(-500, 500);
    repeat (4) send(500, -500);
    bus_if.sample_valid = 1'b0;
    repeat (3) tick();
    check("ovf_held_valid", 32'(bus_if.bits_valid), 1);
    check("ovf_held_bits", 32'(bus_if.bits), 2);
    check("ovf_flag", 32'(bus_if.overflow), 1);
    bus_if.bits_ready = 1'b1;
    tick();
    check("ovf_consumed_valid", 32'(bus_if.bits_valid), 0);
    check("ovf_sticky", 32'(bus_if.overflow), 1);
    drain("ovf");

    // Asynchronous reset mid-symbol, then a clean symbol.
    repeat (2) send(300, 300);
    bus_if.sample_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    check("arst_bits", 32'(bus_if.bits), 0);
    check("arst_valid", 32'(bus_if.bits_valid), 0);
    check("arst_overflow", 32'(bus_if.overflow), 0);
    tick();
    rst = 1'b0;
    tick();
    exp_q.push_back(2'b11);
    repeat (4) send(-20, -30);
    drain("arst_resume");

`ifdef CCSDS_DEMOD_SOFT_EN
    // 16 x +4095: 65520 >>> 7 = 511 saturates to +127; Q sum 0 -> soft 0.
    restart(16);
    exp_q.push_back(2'b00);
    repeat (16) send(QPSK_AMPL, 0);
    drain("soft");
    check("soft_i_sat", 32'(soft_i), 127);
    check("soft_q_zero", 32'(soft_q), 0);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
